// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: single-port frame-buffer RAM arbiter, VGA first, CPU starvation-limited.
// Define ARB_STATS_EN to build the grant statistics counters.
module fb_mem_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_stall,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [31:0]       stat_vga_cnt,
    output logic [31:0]       stat_cpu_cnt,
    output logic [15:0]       stat_force_cnt
);

    typedef enum logic {
        IDLE,
        CPU_WAIT
    } state_t;

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        starve_cnt;
    logic [7:0]        starve_nx;
    logic              vga_own;
    logic              cpu_rd_own;
    logic [DATA_W-1:0] cpu_rdata_q;

    logic cpu_eligible;
    logic force_cpu;
    logic grant_vga;
    logic grant_cpu;

    always_comb begin
        cpu_eligible = cpu_req & (state != CPU_WAIT) & ~reset;
        force_cpu    = cpu_eligible & (starve_cnt == LIM);
        grant_vga    = vga_req & ~reset & ~force_cpu;
        grant_cpu    = cpu_eligible & (force_cpu | ~vga_req);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        starve_nx = starve_cnt;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        vga_stall = vga_req & force_cpu;

        unique case (state)
            IDLE:     if (grant_cpu) state_nx = CPU_WAIT;
            CPU_WAIT: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase

        if (grant_cpu || !cpu_req)
            starve_nx = '0;
        else if (cpu_eligible && grant_vga && starve_cnt < LIM)
            starve_nx = starve_cnt + 8'd1;

        unique case (1'b1)
            grant_cpu: begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_we ? cpu_wdata : '0;
            end
            grant_vga: begin
                mem_en   = 1'b1;
                mem_addr = vga_addr;
            end
            default: ;
        endcase
    end

    // Owner tags for the one-cycle RAM return path
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_own     <= 1'b0;
            cpu_rd_own  <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            vga_own    <= grant_vga;
            cpu_rd_own <= grant_cpu & ~cpu_we;
            if (cpu_ack && cpu_rd_own)
                cpu_rdata_q <= mem_rdata;
        end
    end

    always_comb begin
        vga_rvalid = vga_own & ~reset;
        vga_rdata  = vga_rvalid ? mem_rdata : '0;
        cpu_ack    = (state == CPU_WAIT) & ~reset;
        if (reset)
            cpu_rdata = '0;
        else if (cpu_ack && cpu_rd_own)
            cpu_rdata = mem_rdata;
        else
            cpu_rdata = cpu_rdata_q;
    end

`ifdef ARB_STATS_EN
    logic [31:0] vga_cnt;
    logic [31:0] cpu_cnt;
    logic [15:0] force_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            vga_cnt   <= '0;
            cpu_cnt   <= '0;
            force_cnt <= '0;
        end else begin
            if (grant_vga && vga_cnt != '1)
                vga_cnt <= vga_cnt + 32'd1;
            if (grant_cpu && cpu_cnt != '1)
                cpu_cnt <= cpu_cnt + 32'd1;
            if (grant_cpu && force_cpu && force_cnt != '1)
                force_cnt <= force_cnt + 16'd1;
        end
    end

    assign stat_vga_cnt   = vga_cnt;
    assign stat_cpu_cnt   = cpu_cnt;
    assign stat_force_cnt = force_cnt;
`else
    assign stat_vga_cnt   = '0;
    assign stat_cpu_cnt   = '0;
    assign stat_force_cnt = '0;
`endif

endmodule
